// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load value, run controls and count/expiry status.
interface countdown_timer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] x;
   logic             load_x;
   logic             start;
   logic             stop;
   logic             auto_reload;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             expired;

   modport master (
      output x, load_x, start, stop, auto_reload,
      input  y, busy, expired
   );

   modport slave (
      input  x, load_x, start, stop, auto_reload,
      output y, busy, expired
   );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle expiry pulse and optional auto-reload for periodic ticks.
module countdown_timer #(
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   countdown_timer_if.slave  bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_y;
   logic [WIDTH-1:0] w_y_nxt;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             r_expired;
   logic             w_expired_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_y       <= '0;
         r_reload  <= '0;
         r_expired <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_y       <= w_y_nxt;
         r_reload  <= w_reload_nxt;
         r_expired <= w_expired_nxt;
      end
   end

   // Priority: load_x > stop > start > decrement; expired defaults low every cycle.
   always_comb begin
      w_state_nxt   = r_state;
      w_y_nxt       = r_y;
      w_reload_nxt  = r_reload;
      w_expired_nxt = 1'b0;
      if (bus.load_x) begin
         w_y_nxt      = bus.x;
         w_reload_nxt = bus.x;
         if ((bus.x == '0) || bus.stop) begin
            w_state_nxt = IDLE;
         end else if (bus.start) begin
            w_state_nxt = RUN;
         end
      end else if (bus.stop) begin
         w_state_nxt = IDLE;
      end else if (r_state == IDLE) begin
         if (bus.start && (r_y != '0)) begin
            w_state_nxt = RUN;
         end
      end else if (r_y == WIDTH'(1)) begin
         w_expired_nxt = 1'b1;
         if (bus.auto_reload) begin
            w_y_nxt = r_reload;
         end else begin
            w_y_nxt     = '0;
            w_state_nxt = IDLE;
         end
      end else begin
         // RUN never holds zero, so this cannot wrap.
         w_y_nxt = r_y - WIDTH'(1);
      end
   end

   assign bus.y       = r_y;
   assign bus.busy    = (r_state == RUN);
   assign bus.expired = r_expired;

endmodule
